tp_pipe_mul_sat: RTL

//  Parametrised, pipelined signed fixed-point multiplier for the tracklet calculation datapath.

---
 rtl/tp_pipe_mul_sat_if.sv | 28 ++
 rtl/tp_pipe_mul_sat.sv | 111 +++++++++++
 2 files changed

// File: rtl/tp_pipe_mul_sat_if.sv
// Streaming operand/result bundle for tp_pipe_mul_sat, plus the overflow counter sideband.
interface tp_pipe_mul_sat_if #(
   parameter int unsigned A_W   = 16,
   parameter int unsigned B_W   = 16,
   parameter int unsigned P_W   = 30,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [A_W-1:0]   a;
   logic [B_W-1:0]   b;
   logic             out_valid;
   logic             out_ready;
   logic [P_W-1:0]   p;
   logic             ovf;
   logic [CNT_W-1:0] ovf_cnt;
   logic             clr_cnt;

   modport master (
      output in_valid, a, b, out_ready, clr_cnt,
      input  in_ready, out_valid, p, ovf, ovf_cnt
   );

   modport slave (
      input  in_valid, a, b, out_ready, clr_cnt,
      output in_ready, out_valid, p, ovf, ovf_cnt
   );
endinterface

// File: rtl/tp_pipe_mul_sat.sv
// Pipelined signed fixed-point multiplier with scaling, optional rounding/saturation,
// overflow flag/counter and a bubble-collapsing valid/ready pipeline.
module tp_pipe_mul_sat #(
   parameter int unsigned A_W       = 16,
   parameter int unsigned B_W       = 16,
   parameter int unsigned P_W       = 30,
   parameter int unsigned NUM_STAGE = 3,
   parameter int unsigned SHIFT     = 0,
   parameter int unsigned RND       = 0,
   parameter int unsigned SAT       = 1,
   parameter int unsigned CNT_W     = 16
) (
   input logic               ap_clk,
   input logic               ap_rst,
   tp_pipe_mul_sat_if.slave  bus_io
);
   localparam int unsigned W  = A_W + B_W;
   localparam int unsigned RW = W + 1;
   localparam int unsigned PN = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
   localparam logic signed [RW-1:0] RndC =
      (RND != 0 && SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

   logic [NUM_STAGE-1:0] v_q, v_d, adv, v_in;
   logic                 rdy_q;
   logic                 acc;
   logic                 ld_last;
   logic signed [W-1:0]  mul, sc_in;
   logic signed [W-1:0]  prod_q [PN];
   logic signed [W-1:0]  prod_d [PN];
   logic signed [RW-1:0] ext, r;
   logic [P_W-1:0]       sc_p, p_q, p_d;
   logic                 sc_ovf, ovf_q, ovf_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // A stage may move whenever any stage at or below it is empty or the sink is taking.
   for (genvar k = 0; k < NUM_STAGE; k++) begin : g_adv
      assign adv[k] = bus_io.out_ready | ~(&v_q[NUM_STAGE-1:k]);
   end

   assign bus_io.in_ready = rdy_q & adv[0];
   assign acc             = bus_io.in_valid & bus_io.in_ready;
   assign v_in            = NUM_STAGE'({v_q, acc});
   assign v_d             = (adv & v_in) | (~adv & v_q);
   assign ld_last         = adv[NUM_STAGE-1] & v_in[NUM_STAGE-1];

   assign mul = W'($signed(bus_io.a)) * W'($signed(bus_io.b));

   if (NUM_STAGE > 1) begin : g_prod
      assign prod_d[0] = (adv[0] && acc) ? mul : prod_q[0];
      for (genvar k = 1; k < NUM_STAGE - 1; k++) begin : g_retime
         assign prod_d[k] = (adv[k] && v_q[k-1]) ? prod_q[k-1] : prod_q[k];
      end
      assign sc_in = prod_q[NUM_STAGE-2];
   end else begin : g_noprod
      assign prod_d[0] = prod_q[0];
      assign sc_in     = mul;
   end

   // One guard bit keeps the rounding add from wrapping the most negative product squared.
   assign ext = RW'(sc_in) + RndC;
   assign r   = ext >>> SHIFT;

   if (P_W < RW) begin : g_chk
      logic [RW-P_W:0] hi;
      assign hi     = r[RW-1:P_W-1];
      assign sc_ovf = !((&hi) || !(|hi));
      if (SAT != 0) begin : g_sat
         assign sc_p = !sc_ovf ? r[P_W-1:0] :
                       r[RW-1] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
      end else begin : g_wrap
         assign sc_p = r[P_W-1:0];
      end
   end else begin : g_wide
      assign sc_ovf = 1'b0;
      assign sc_p   = P_W'(r);
   end

   always_comb begin
      p_d   = ld_last ? sc_p : p_q;
      ovf_d = ld_last ? sc_ovf : ovf_q;
      cnt_d = cnt_q;
      if (bus_io.clr_cnt) begin
         cnt_d = '0;
      end else if (v_q[NUM_STAGE-1] && bus_io.out_ready && ovf_q && cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         v_q    <= '0;
         rdy_q  <= 1'b0;
         prod_q <= '{default: '0};
         p_q    <= '0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         v_q    <= v_d;
         rdy_q  <= 1'b1;
         prod_q <= prod_d;
         p_q    <= p_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus_io.out_valid = v_q[NUM_STAGE-1];
   assign bus_io.p         = p_q;
   assign bus_io.ovf       = ovf_q;
   assign bus_io.ovf_cnt   = cnt_q;
endmodule
